ram_sp_param: RTL
=================

Name: ram_sp_param

Overview:
Parametrised single-port synchronous RAM; next generation of the fixed 64x16 scratch RAM. Adds configurable depth and width, per-byte write enables, a selectable data_out behaviour on writes, a read-valid strobe, and an optional hardware clear sweep after reset with a busy indication. Sits beside the core as data/scratch memory. With default parameters it is a drop-in superset of the 64x16 RAM.

Parameters:
ADDR_W, 6, address width; depth = 2**ADDR_W words.
DATA_W, 16, word width; must be a multiple of BYTE_W.
BYTE_W, 8, byte-lane width; NB = DATA_W/BYTE_W lanes.
WR_MODE, 0, data_out on write: 0 = NO_CHANGE, 1 = READ_FIRST, 2 = WRITE_FIRST.
CLEAR_ON_RESET, 1, 1 = sweep every word to CLEAR_VALUE after reset; 0 = no sweep, contents undefined.
CLEAR_VALUE, 0, DATA_W-bit fill value for the sweep.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-high.
ce  in  1  chip enable; no access without it.
enable  in  1  access enable; access needs ce=1 and enable=1.
r_w  in  1  0 = read, 1 = write.
be  in  NB  byte-lane write enables; bit i covers data_in[i*BYTE_W +: BYTE_W].
add  in  ADDR_W  word address.
data_in  in  DATA_W  write data.
data_out  out  DATA_W  registered read data.
rd_valid  out  1  one-cycle pulse: data_out updated by a read.
busy  out  1  high while reset is asserted or the clear sweep runs; accesses ignored.

Behaviour:
- Reset (async, while rst=1): data_out=0, rd_valid=0, busy=1, clear counter=0, state=CLEAR if CLEAR_ON_RESET else READY. Memory contents are not touched by rst itself.
- FSM states: CLEAR, READY.
  - CLEAR: each clk writes CLEAR_VALUE to memory[cnt], then cnt+1. ce, enable, r_w, be, add and data_in are ignored.
  - The sweep takes exactly 2**ADDR_W cycles after rst deasserts. On the cycle that writes the last address, the FSM moves to READY. busy drops at that edge.
  - READY: normal access. Stays there until the next rst.
- With CLEAR_ON_RESET=0, busy drops at the first clk edge after rst deasserts.
- busy is registered: 1 in CLEAR and during reset, 0 in READY.
- Access is valid when state=READY, ce=1 and enable=1. Otherwise there is no memory change, data_out holds, and rd_valid=0.
- Read (r_w=0):
  - data_out <= memory[add] at the edge; latency 1 cycle.
  - rd_valid=1 for the following cycle only. Back-to-back reads give back-to-back pulses.
- Write (r_w=1):
  - For each lane i with be[i]=1, memory[add] lane i <= data_in lane i. Lanes with be[i]=0 are unchanged.
  - be=0 is a legal no-op write.
  - rd_valid=0 on any write.
  - data_out on a write, per WR_MODE:
    - NO_CHANGE: holds (legacy behaviour).
    - READ_FIRST: the pre-write word.
    - WRITE_FIRST: the merged post-write word.
- Read after write to the same address on the next cycle returns the merged word. There is no read/write collision on a single port.
- rst asserted mid-sweep or mid-access: the outputs reset immediately and the sweep restarts from address 0. A write in flight at the rst edge is discarded.
- Address wrap: the clear counter is ADDR_W+1 bits internally, so there is no wrap at the last address. add has no wrap concerns (full range is valid).
- Elaboration: DATA_W % BYTE_W != 0 or WR_MODE > 2 is a fatal error.

Test Plan:
- Clear sweep (defaults, CLEAR_VALUE=16'hA5A5): pulse rst, release -> busy=1 for exactly 64 cycles then 0; reads of addresses 0, 31 and 63 return 16'hA5A5 with rd_valid pulsing 1 cycle after each.
- Access during busy: write 16'h1234 @ 5 issued on sweep cycle 2 -> ignored; after busy falls, read @5 returns CLEAR_VALUE.
- Byte enables: write 16'hFFFF @ 10 with be=2'b11, then 16'h1200 with be=2'b10 -> read @10 = 16'h12FF; be=2'b00 write of 16'h0000 -> still 16'h12FF.
- WR_MODE sweep (memory[3]=16'h00AA, write 16'h5500 with be=2'b10, prior data_out=16'hBEEF) -> data_out = 16'hBEEF (NO_CHANGE) / 16'h00AA (READ_FIRST) / 16'h55AA (WRITE_FIRST); rd_valid=0 in all three.
- Gating: ce=0 or enable=0 with r_w=1, add=7, data_in=16'h7777 -> memory[7] unchanged, data_out holds, rd_valid=0.
- Reset mid-sweep: assert rst at sweep cycle 30 -> data_out=0 and busy=1 immediately; after release, busy lasts a full 64 cycles. Repeat with ADDR_W=4, DATA_W=32 -> 16-cycle sweep, 4-lane be works.

Source files
------------

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with per-byte write enables, selectable
// data_out behaviour on writes, a read-valid strobe and an optional post-reset clear sweep.
module ram_sp_param #(
    parameter int unsigned       ADDR_W         = 6,
    parameter int unsigned       DATA_W         = 16,
    parameter int unsigned       BYTE_W         = 8,
    parameter int unsigned       WR_MODE        = 0,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       enable,
    input  logic                       r_w,
    input  logic [DATA_W/BYTE_W-1:0]   be,
    input  logic [ADDR_W-1:0]          add,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       rd_valid,
    output logic                       busy
);

    localparam int unsigned NB    = DATA_W / BYTE_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic STATE_CLEAR = 1'b0;
    localparam logic STATE_READY = 1'b1;
    localparam logic STATE_RESET = CLEAR_ON_RESET ? STATE_CLEAR : STATE_READY;

    if (DATA_W % BYTE_W != 0) begin : g_bad_width
        $fatal(1, "ram_sp_param: DATA_W must be a multiple of BYTE_W");
    end
    if (WR_MODE > 2) begin : g_bad_mode
        $fatal(1, "ram_sp_param: WR_MODE must be 0, 1 or 2");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= STATE_RESET;
            cnt_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, memory write request and output next values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        busy_d     = busy_q;
        mem_we     = 1'b0;
        mem_addr   = add;
        mem_wdata  = CLEAR_VALUE;
        rd_word    = mem_q[add];
        merged     = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[i*BYTE_W +: BYTE_W] = data_in[i*BYTE_W +: BYTE_W];
            end
        end

        case (state_q)
            STATE_CLEAR: begin
                busy_d   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = cnt_q[ADDR_W-1:0];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = STATE_READY;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
                if (ce && enable) begin
                    if (r_w) begin
                        mem_we    = 1'b1;
                        mem_wdata = merged;
                        if (WR_MODE == 1) begin
                            data_out_d = rd_word;
                        end else if (WR_MODE == 2) begin
                            data_out_d = merged;
                        end
                    end else begin
                        data_out_d = rd_word;
                        rd_valid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Storage array; rst never alters contents and discards a write at a reset edge
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule
